// File: rtl/std_fu_pkg.sv
// Shared types and constants for the shared functional-unit sequencing controller.
// The divide-by-zero result is kept wide; users truncate it to their operand width.
package std_fu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } fu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fu_state_e;

    localparam int unsigned DIV0_MAX_W = 256;
    localparam logic [DIV0_MAX_W-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/std_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register lives in the parent.
module std_rr_arbiter #(
    parameter int unsigned num_req = 4
) (
    input  logic [num_req-1:0]         req,
    input  logic [$clog2(num_req)-1:0] ptr,
    output logic [num_req-1:0]         grant,
    output logic [$clog2(num_req)-1:0] grant_idx,
    output logic                       any
);

    localparam int unsigned IW = $clog2(num_req);

    logic [IW:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < num_req; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(num_req)) begin
                pos = pos - (IW+1)'(num_req);
            end
            if (!any && req[pos[IW-1:0]]) begin
                grant[pos[IW-1:0]] = 1'b1;
                grant_idx          = pos[IW-1:0];
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/std_fu_arbiter.sv
// Shares one external arithmetic unit among num_req requesters: round-robin grant,
// registered operands, latency-cycle drive of the unit, one-cycle response pulse.
module std_fu_arbiter
    import std_fu_pkg::*;
#(
    parameter int unsigned width   = 32,
    parameter int unsigned num_req = 4,
    parameter int unsigned latency = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [num_req-1:0]       req_valid,
    input  logic [2*num_req-1:0]     req_op,
    input  logic [width*num_req-1:0] req_left,
    input  logic [width*num_req-1:0] req_right,
    output logic [num_req-1:0]       req_ready,
    output logic [num_req-1:0]       resp_valid,
    output logic [width-1:0]         resp_out,
    output logic                     resp_err,
    output logic                     fu_valid,
    output logic [1:0]               fu_op,
    output logic [width-1:0]         fu_left,
    output logic [width-1:0]         fu_right,
    input  logic                     fu_ready,
    input  logic [width-1:0]         fu_out
);

    localparam int unsigned IW = $clog2(num_req);
    localparam int unsigned CW = (latency > 1) ? $clog2(latency) : 1;
    localparam logic [CW-1:0] LAST = CW'(latency - 1);

    fu_state_e        state, state_n;
    logic [IW-1:0]    ptr, gidx, ptr_next;
    logic [CW-1:0]    cnt;
    fu_op_e           op_r;
    logic [width-1:0] left_r, right_r, result_r;
    logic             err_r;

    logic [num_req-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    logic [1:0]       op_slice    [num_req];
    logic [width-1:0] left_slice  [num_req];
    logic [width-1:0] right_slice [num_req];

    fu_op_e           sel_op;
    logic [width-1:0] sel_left, sel_right;
    logic             div0;

    for (genvar i = 0; i < num_req; i++) begin : g_slice
        assign op_slice[i]    = req_op[2*i +: 2];
        assign left_slice[i]  = req_left[width*i +: width];
        assign right_slice[i] = req_right[width*i +: width];
    end

    std_rr_arbiter #(.num_req(num_req)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign sel_op    = fu_op_e'(op_slice[arb_idx]);
    assign sel_left  = left_slice[arb_idx];
    assign sel_right = right_slice[arb_idx];
    assign div0      = (sel_op == DIV) && (sel_right == '0);
    assign ptr_next  = (arb_idx == IW'(num_req - 1)) ? '0 : arb_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            cnt      <= '0;
            op_r     <= ADD;
            left_r   <= '0;
            right_r  <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        gidx    <= arb_idx;
                        ptr     <= ptr_next;
                        op_r    <= sel_op;
                        left_r  <= sel_left;
                        right_r <= sel_right;
                        cnt     <= '0;
                        err_r   <= div0;
                        if (div0) begin
                            result_r <= width'(DIV0_RESULT);
                        end
                    end
                end
                EXEC: begin
                    // counter saturates at LAST; a low fu_ready there stalls the capture
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (fu_ready) begin
                        result_r <= fu_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulse outputs are masked while reset is low so nothing is advertised in that cycle.
    always_comb begin
        state_n    = state;
        req_ready  = '0;
        resp_valid = '0;
        fu_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    state_n = div0 ? DONE : EXEC;
                end
                if (reset) begin
                    req_ready = arb_grant;
                end
            end
            EXEC: begin
                if (cnt == LAST && fu_ready) begin
                    state_n = DONE;
                end
                fu_valid = reset;
            end
            DONE: begin
                state_n = IDLE;
                if (reset) begin
                    resp_valid = num_req'(1) << gidx;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fu_op    = op_r;
    assign fu_left  = left_r;
    assign fu_right = right_r;
    assign resp_out = result_r;
    assign resp_err = err_r;

endmodule
